// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants and helpers for the VGA timing generator.
//   - XGA (1024x768@60, 65 MHz pixel clock) default timing set
//   - SVGA (800x600@60, 40 MHz pixel clock) timing set
//   - axis_total(): full period of one axis (active + porches + sync)
//   - in_sync_window(): true when a position lies inside the sync pulse
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // XGA 1024x768@60, 65 MHz pixel clock, negative syncs
  localparam int XGA_PCLK_HZ  = 65_000_000;
  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam bit XGA_HS_POL   = 1'b0;
  localparam bit XGA_VS_POL   = 1'b0;

  // SVGA 800x600@60, 40 MHz pixel clock, positive syncs
  localparam int SVGA_PCLK_HZ  = 40_000_000;
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;
  localparam bit SVGA_HS_POL   = 1'b1;
  localparam bit SVGA_VS_POL   = 1'b1;

  // Number of positions in one axis period
  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  // Sync pulse occupies [active+fp, active+fp+sync)
  function automatic logic in_sync_window(int pos, int active, int fp, int sync);
    return (pos >= active + fp) && (pos < active + fp + sync);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One axis (horizontal or vertical) of the VGA raster. Counts 0..TOTAL-1
// while inc is high and derives registered blanking and sync that always
// match the registered count.
// Ports:
//   pclk   in   pixel clock, rising edge
//   rst    in   synchronous active-high reset
//   inc    in   advance the count this cycle
//   count  out  current position (registered)
//   blnk   out  1 when count >= ACTIVE (registered)
//   sync   out  POL inside the sync window, ~POL elsewhere (registered)
//   wrap   out  combinational: this cycle advances from TOTAL-1 back to 0
// ---------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 1024,
  parameter int FP     = 24,
  parameter int SYNC   = 136,
  parameter int BP     = 160,
  parameter bit POL    = 1'b0,
  parameter int CW     = 11
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          blnk,
  output logic          sync,
  output logic          wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACTIVE_CNT = CW'(ACTIVE);

  // Refuse to build with zero-width regions or a counter too narrow
  if (ACTIVE <= 0 || FP <= 0 || SYNC <= 0 || BP <= 0) begin : g_bad_region
    $error("vga_axis_counter: ACTIVE, FP, SYNC and BP must all be non-zero");
  end
  if (TOTAL > 2 ** CW) begin : g_bad_width
    $error("vga_axis_counter: axis total does not fit in CW bits");
  end

  logic [CW-1:0] count_next;
  logic          blnk_next;
  logic          sync_next;

  // Blank and sync are decoded from the next count so that, once
  // registered, they line up with the registered count in the same cycle.
  always_comb begin
    wrap       = inc && (count == LAST);
    count_next = count;
    if (inc) begin
      count_next = wrap ? '0 : count + 1'b1;
    end
    blnk_next = (count_next >= ACTIVE_CNT);
    sync_next = in_sync_window(int'(count_next), ACTIVE, FP, SYNC) ? POL : ~POL;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= ~POL;
    end else begin
      count <= count_next;
      blnk  <= blnk_next;
      sync  <= sync_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. Default timing is XGA 1024x768.
// Ports:
//   pclk       in   pixel clock, rising edge
//   rst        in   synchronous active-high reset (overrides ce)
//   ce         in   pixel enable; counters advance only when 1
//   hcount     out  horizontal position 0..H_TOTAL-1
//   vcount     out  vertical position 0..V_TOTAL-1
//   hblnk      out  horizontal blanking
//   vblnk      out  vertical blanking
//   hsync      out  horizontal sync at HS_POL level inside its window
//   vsync      out  vertical sync at VS_POL level inside its window
//   de         out  data enable, ~hblnk & ~vblnk
//   eol        out  one-pclk strobe coinciding with hcount wrapping to 0
//   sof        out  one-pclk strobe coinciding with the frame wrap
//   frame_cnt  out  completed-frame count, wraps modulo 2^FRAME_W
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP     = XGA_H_FP,
  parameter int H_SYNC   = XGA_H_SYNC,
  parameter int H_BP     = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP     = XGA_V_FP,
  parameter int V_SYNC   = XGA_V_SYNC,
  parameter int V_BP     = XGA_V_BP,
  parameter bit HS_POL   = XGA_HS_POL,
  parameter bit VS_POL   = XGA_VS_POL,
  parameter int CW       = 11,
  parameter int FRAME_W  = 16
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               ce,
  output logic [CW-1:0]      hcount,
  output logic [CW-1:0]      vcount,
  output logic               hblnk,
  output logic               vblnk,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               eol,
  output logic               sof,
  output logic [FRAME_W-1:0] frame_cnt
);

  // Last visible position on each axis; one step past it enters blanking
  localparam logic [CW-1:0] H_LAST_ACTIVE = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_LAST_ACTIVE = CW'(V_ACTIVE - 1);

  logic h_wrap;
  logic v_wrap;
  logic v_inc;
  logic h_blnk_next;
  logic v_blnk_next;
  logic de_next;

  assign v_inc = ce & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
  ) u_h_axis (
    .pclk  (pclk),
    .rst   (rst),
    .inc   (ce),
    .count (hcount),
    .blnk  (hblnk),
    .sync  (hsync),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
  ) u_v_axis (
    .pclk  (pclk),
    .rst   (rst),
    .inc   (v_inc),
    .count (vcount),
    .blnk  (vblnk),
    .sync  (vsync),
    .wrap  (v_wrap)
  );

  // de is registered from the next-cycle blanking so it stays aligned with
  // the counts instead of being a gate on the axis outputs. A wrap always
  // lands on position 0, which is visible.
  always_comb begin
    h_blnk_next = hblnk;
    v_blnk_next = vblnk;
    if (ce) begin
      h_blnk_next = h_wrap ? 1'b0 : (hcount >= H_LAST_ACTIVE);
      if (h_wrap) begin
        v_blnk_next = v_wrap ? 1'b0 : (vcount >= V_LAST_ACTIVE);
      end
    end
    de_next = ~h_blnk_next & ~v_blnk_next;
  end

  // Strobes follow the wrap terms directly, so with ce low they drop on
  // the next edge and can never stretch beyond one pclk.
  always_ff @(posedge pclk) begin
    if (rst) begin
      de        <= 1'b1;
      eol       <= 1'b0;
      sof       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      de  <= de_next;
      eol <= h_wrap;
      sof <= v_wrap;
      if (v_wrap) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Three generators share pclk/rst/ce: XGA defaults, a tiny raster
// (15x8, positive syncs, 2-bit frame counter) that completes frames
// quickly, and SVGA 800x600 with positive syncs. A reference model pushes
// the expected outputs of every DUT into a queue as each stimulus is
// driven; they are popped and compared once the edge has happened.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    bit hp, vp;
    int fmod;
  } cfg_t;

  typedef struct {
    int h, v, fc;
    bit eol, sof;
  } mstate_t;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic ce   = 1'b0;

  logic [10:0] a_hcount, a_vcount;
  logic        a_hblnk, a_vblnk, a_hsync, a_vsync, a_de, a_eol, a_sof;
  logic [15:0] a_frame_cnt;

  logic [3:0]  b_hcount, b_vcount;
  logic        b_hblnk, b_vblnk, b_hsync, b_vsync, b_de, b_eol, b_sof;
  logic [1:0]  b_frame_cnt;

  logic [10:0] c_hcount, c_vcount;
  logic        c_hblnk, c_vblnk, c_hsync, c_vsync, c_de, c_eol, c_sof;
  logic [15:0] c_frame_cnt;

  cfg_t        cfg [3];
  mstate_t     ms  [3];
  logic [63:0] exp_q [$];
  string       tags [3];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int last_eol = -1;
  int last_sof = -1;
  int eol_period = 1344;
  int sof_period = 120;
  int sof_idx = 0;

  always #5 pclk = ~pclk;

  // XGA defaults, no parameter overrides
  vga_timing_gen u_dut_a (
    .pclk(pclk), .rst(rst), .ce(ce),
    .hcount(a_hcount), .vcount(a_vcount), .hblnk(a_hblnk), .vblnk(a_vblnk),
    .hsync(a_hsync), .vsync(a_vsync), .de(a_de), .eol(a_eol), .sof(a_sof),
    .frame_cnt(a_frame_cnt)
  );

  // Tiny raster: H 8/2/3/2 = 15, V 4/1/2/1 = 8, 120 pixels per frame
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .FRAME_W(2)
  ) u_dut_b (
    .pclk(pclk), .rst(rst), .ce(ce),
    .hcount(b_hcount), .vcount(b_vcount), .hblnk(b_hblnk), .vblnk(b_vblnk),
    .hsync(b_hsync), .vsync(b_vsync), .de(b_de), .eol(b_eol), .sof(b_sof),
    .frame_cnt(b_frame_cnt)
  );

  // SVGA 800x600, positive syncs
  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(11), .FRAME_W(16)
  ) u_dut_c (
    .pclk(pclk), .rst(rst), .ce(ce),
    .hcount(c_hcount), .vcount(c_vcount), .hblnk(c_hblnk), .vblnk(c_vblnk),
    .hsync(c_hsync), .vsync(c_vsync), .de(c_de), .eol(c_eol), .sof(c_sof),
    .frame_cnt(c_frame_cnt)
  );

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cycle);
    end
  endtask

  function automatic logic [63:0] pack(int h, int v, logic hb, logic vb, logic hs,
                                       logic vs, logic d, logic e, logic s, int fc);
    return {9'd0, 16'(h), 16'(v), hb, vb, hs, vs, d, e, s, 16'(fc)};
  endfunction

  // Raster model: what one pclk edge does to the timing state
  function automatic mstate_t model_step(mstate_t s, cfg_t c, bit r, bit e);
    mstate_t n;
    int ht, vt;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    n = s;
    if (r) begin
      n.h = 0; n.v = 0; n.fc = 0; n.eol = 1'b0; n.sof = 1'b0;
    end else if (!e) begin
      n.eol = 1'b0; n.sof = 1'b0;
    end else begin
      n.eol = (s.h == ht - 1);
      n.sof = 1'b0;
      if (n.eol) begin
        n.h = 0;
        if (s.v == vt - 1) begin
          n.v   = 0;
          n.sof = 1'b1;
          n.fc  = (s.fc + 1) % c.fmod;
        end else begin
          n.v = s.v + 1;
        end
      end else begin
        n.h = s.h + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] model_out(mstate_t s, cfg_t c);
    logic hb, vb, hs, vs;
    hb = (s.h >= c.ha);
    vb = (s.v >= c.va);
    hs = (s.h >= c.ha + c.hf && s.h < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
    vs = (s.v >= c.va + c.vf && s.v < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
    return pack(s.h, s.v, hb, vb, hs, vs, ~hb & ~vb, s.eol, s.sof, s.fc);
  endfunction

  // Drive one pclk of stimulus, queue the model's expectation, then
  // compare every DUT against it and run the strobe-timing monitors.
  task automatic applyStimulus(input bit r, input bit e);
    logic [63:0] obs [3];
    rst = r;
    ce  = e;
    for (int i = 0; i < 3; i++) begin
      ms[i] = model_step(ms[i], cfg[i], r, e);
      exp_q.push_back(model_out(ms[i], cfg[i]));
    end
    @(posedge pclk);
    #1;
    cycle++;
    obs[0] = pack(int'(a_hcount), int'(a_vcount), a_hblnk, a_vblnk, a_hsync, a_vsync,
                  a_de, a_eol, a_sof, int'(a_frame_cnt));
    obs[1] = pack(int'(b_hcount), int'(b_vcount), b_hblnk, b_vblnk, b_hsync, b_vsync,
                  b_de, b_eol, b_sof, int'(b_frame_cnt));
    obs[2] = pack(int'(c_hcount), int'(c_vcount), c_hblnk, c_vblnk, c_hsync, c_vsync,
                  c_de, c_eol, c_sof, int'(c_frame_cnt));
    for (int i = 0; i < 3; i++) begin
      checkOutput(tags[i], obs[i], exp_q.pop_front());
    end
    if (r) begin
      last_eol = -1;
      last_sof = -1;
      sof_idx  = 0;
    end
    if (a_eol) begin
      if (last_eol >= 0) checkOutput("xga_eol_period", 64'(cycle - last_eol), 64'(eol_period));
      last_eol = cycle;
    end
    if (b_sof) begin
      if (last_sof >= 0) checkOutput("small_sof_period", 64'(cycle - last_sof), 64'(sof_period));
      last_sof = cycle;
      sof_idx++;
      checkOutput("small_frame_seq", 64'(b_frame_cnt), 64'(sof_idx % 4));
      checkOutput("small_eol_with_sof", 64'(b_eol), 64'd1);
    end
  endtask

  task automatic startPhase(input int eol_p, input int sof_p);
    eol_period = eol_p;
    sof_period = sof_p;
    last_eol   = -1;
    last_sof   = -1;
  endtask

  initial begin
    cfg[0] = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0, 65536};
    cfg[1] = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1, 4};
    cfg[2] = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 65536};
    tags[0] = "xga_outputs";
    tags[1] = "small_outputs";
    tags[2] = "svga_outputs";
    for (int i = 0; i < 3; i++) ms[i] = '{0, 0, 0, 1'b0, 1'b0};

    $display("[TB] reset");
    repeat (2) applyStimulus(1'b1, 1'b0);

    $display("[TB] continuous pixel enable");
    startPhase(1344, 120);
    repeat (3 * 1344 + 8) applyStimulus(1'b0, 1'b1);

    $display("[TB] pixel enable toggling 1,0,1,0");
    startPhase(2 * 1344, 2 * 120);
    for (int i = 0; i < 8200; i++) applyStimulus(1'b0, (i % 2) == 0);

    $display("[TB] reset in the middle of a line");
    startPhase(1344, 120);
    for (int i = 0; i < 3000 && !(ms[0].h == 500 && ms[0].v >= 1); i++) begin
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("xga_reach_h500", 64'(a_hcount), 64'd500);
    applyStimulus(1'b1, 1'b1);
    checkOutput("xga_midline_reset",
                {19'd0, a_hcount, a_vcount, a_hblnk, a_vblnk, a_de, a_hsync, a_vsync,
                 a_eol, a_sof, a_frame_cnt},
                {19'd0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0});

    $display("[TB] five small frames after reset");
    startPhase(1344, 120);
    repeat (5 * 120 + 10) applyStimulus(1'b0, 1'b1);
    checkOutput("small_sof_count", 64'(sof_idx), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 1024x768 timing generator. It produces horizontal and vertical pixel counts, blanking, sync and data-enable for any resolution.
- Adds configurable sync polarity, a pixel clock-enable for divided pixel rates, line and frame strobes, and a frame counter.
- Sits directly after the clock generator. It feeds the background/sprite draw pipeline and the VGA output pins.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CW, 11, width of hcount/vcount
- FRAME_W, 16, width of frame counter

Ports:
- pclk  in  1  pixel clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- ce  in  1  pixel enable; counters advance only when 1
- hcount  out  CW  horizontal position, 0..H_TOTAL-1
- vcount  out  CW  vertical position, 0..V_TOTAL-1
- hblnk  out  1  1 when hcount >= H_ACTIVE
- vblnk  out  1  1 when vcount >= V_ACTIVE
- hsync  out  1  sync at HS_POL level when in the sync window
- vsync  out  1  sync at VS_POL level when in the sync window
- de  out  1  ~hblnk & ~vblnk
- eol  out  1  one-pclk strobe on the line wrap
- sof  out  1  one-pclk strobe on the frame wrap
- frame_cnt  out  FRAME_W  completed-frame count

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806).
- Elaboration must fail if H_TOTAL > 2^CW or V_TOTAL > 2^CW, or if any porch/sync parameter is 0.
- All outputs are registered. hblnk, vblnk, hsync, vsync and de always correspond to the hcount/vcount values on the same cycle. They are computed from next-state counts, so latency relative to the counts is 0.
- Horizontal counting: on pclk with ce=1, hcount increments. At H_TOTAL-1 it wraps to 0 and eol is asserted for that one cycle.
- Vertical counting: vcount increments only on an hcount wrap. At V_TOTAL-1, on an hcount wrap, vcount wraps to 0. In that cycle sof=1 and frame_cnt increments.
- frame_cnt wraps modulo 2^FRAME_W with no saturation.
- hsync window: hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Default window is 1048..1183.
- vsync window: vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). Default window is 771..776. vsync changes together with the hcount wrap, i.e. at line start.
- Inactive sync level is ~POL.
- ce=0: counts, blank, sync, de and frame_cnt hold. eol and sof clear to 0 on the next pclk, so a strobe is never wider than one pclk.
- rst=1 (takes priority over ce, including mid-line or mid-frame): next edge sets hcount=0, vcount=0, hblnk=0, vblnk=0, de=1, hsync=~HS_POL, vsync=~VS_POL, eol=0, sof=0, frame_cnt=0.
- The first frame after reset is not flagged by sof. sof marks wraps only.
- Simultaneous eol and sof on a frame wrap: both are 1 in the same cycle.

Decomposition:
- Package vga_timing_pkg holds:
  - XGA default constants (1024x768@60, 65 MHz)
  - an 800x600 constant set
  - derived H_TOTAL/V_TOTAL functions
  - a sync-window helper
- Sub-module vga_axis_counter, instantiated twice (H and V).
  - Parameters: ACTIVE, FP, SYNC, BP, POL, CW.
  - Ports: pclk, rst, inc, count, blnk, sync, wrap.
  - The H instance takes inc=ce. The V instance takes inc = ce & h_wrap.

Test Plan:
- Reset then ce=1 continuously, defaults:
  - hsync falls at hcount=1048 and rises at 1184.
  - hblnk rises at 1024.
  - eol pulses at hcount 1343→0.
  - 1344 pclk between eol pulses.
- Run a full frame:
  - vsync is low for vcount 771..776.
  - vblnk is 1 for 768..805.
  - sof asserts once after 1344*806 = 1,083,264 enabled cycles, with eol in the same cycle.
  - frame_cnt becomes 1.
- ce toggling 1,0,1,0:
  - counts advance every other pclk; frame period doubles to 2,166,528 pclk.
  - eol/sof stay one pclk wide.
- Assert rst at hcount=500, vcount=300 for one cycle:
  - next cycle hcount=0, vcount=0, de=1, syncs inactive, frame_cnt=0, sof=0.
- Reparametrise to 800x600 (40/128/88, 1/4/23, HS_POL=1, VS_POL=1):
  - H_TOTAL=1056, V_TOTAL=628.
  - hsync high for hcount 840..967.
  - vsync high for vcount 601..604.
- FRAME_W=2, run 5 frames:
  - frame_cnt sequence 1,2,3,0,1.
